wb_arbiter: RTL

Registered writeback arbiter that collects results from `NFU` function units, each presenting `EWD` response lanes. It compacts accepted results into `EWD` output lanes held in a register stage and forwards them to the ROB. It sits between the function units and the ROB, and replaces fixed-priority result selection with rotating-priority selection, per-lane backpressure hold and optional starvation aging.

---
 rtl/wb_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter
//   Registered writeback arbiter. Collects results from NFU function units,
//   each offering EWD response lanes. Accepted results are compacted into
//   EWD registered output lanes for the ROB. FUs are scanned in
//   rotating-priority order. Occupied output lanes that the ROB does not
//   consume hold their value.
//
//   Bundle layout (one lane, BW = DW + 16 bits): {data[DW-1:0], opid[15:0]}.
//   An entry is valid when opid[15] (bit 15 of the lane) is 1.
//
//   Optional feature macro: WB_AGE_EN
//     When defined, each FU has a saturating age counter. The lowest-index
//     FU whose age has reached AGE_MAX is scanned ahead of the rotating
//     order.
//
//   Ports
//     clk         in   clock, rising edge
//     rst         in   asynchronous active-low reset
//     fu_resp     in   [NFU][EWD] result lanes from the function units
//     fu_claim    out  [NFU][EWD] combinational accept strobes
//     execute     in   [EWD] ROB consume strobe per output lane
//     exe_bundle  out  [EWD] registered output lanes
module wb_arbiter #(
    parameter int  NFU     = 5,
    parameter int  EWD     = 4,
    parameter int  AGE_MAX = 7,
    parameter int  DW      = 32,
    localparam int BW      = DW + 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NFU-1:0][EWD-1:0][BW-1:0] fu_resp,
    output logic [NFU-1:0][EWD-1:0]         fu_claim,
    input  logic [EWD-1:0]                  execute,
    output logic [EWD-1:0][BW-1:0]          exe_bundle
);

    localparam int FW = (NFU > 1) ? $clog2(NFU) : 1;
    localparam int LW = (EWD > 1) ? $clog2(EWD) : 1;
    localparam int VB = 15;

    if (NFU < 1 || EWD < 1 || AGE_MAX < 1) begin : g_param_check
        $error("wb_arbiter: NFU, EWD and AGE_MAX must all be >= 1");
    end

    logic [EWD-1:0][BW-1:0]  bundle_q, bundle_d;
    logic [FW-1:0]           rr_q, rr_d;
    logic [NFU-1:0][EWD-1:0] claim;
    logic                    starved;
    logic [FW-1:0]           starved_fu;

    logic [EWD-1:0]          lane_free;
    logic [LW-1:0]           free_idx [EWD];
    logic [LW:0]             nfree;

    logic [FW-1:0]           last_fu;
    logic                    any_grant;
    logic                    any_deny;

    // Free lanes are listed in ascending order so the n-th grant of the
    // cycle lands in free_idx[n].
    always_comb begin : free_lanes
        lane_free = '0;
        nfree     = '0;
        for (int unsigned k = 0; k < EWD; k++) free_idx[k] = '0;
        for (int unsigned k = 0; k < EWD; k++) begin
            lane_free[k] = !bundle_q[k][VB] || execute[k];
            if (lane_free[k]) begin
                free_idx[nfree[LW-1:0]] = LW'(k);
                nfree = nfree + 1'b1;
            end
        end
    end

    always_comb begin : grant
        logic [FW-1:0] scan_fu;
        logic [FW-1:0] cur_fu;
        logic          use_fu;
        logic [LW:0]   gcnt;

        claim     = '0;
        last_fu   = '0;
        any_grant = 1'b0;
        any_deny  = 1'b0;
        scan_fu   = rr_q;
        cur_fu    = '0;
        use_fu    = 1'b0;
        gcnt      = '0;
        for (int unsigned k = 0; k < EWD; k++)
            bundle_d[k] = lane_free[k] ? '0 : bundle_q[k];

        // Slot 0 carries the aged FU (if any); slots 1..NFU walk the ring
        // from rr and skip the aged FU so it is never visited twice.
        for (int unsigned n = 0; n <= NFU; n++) begin
            if (n == 0) begin
                cur_fu = starved_fu;
                use_fu = starved;
            end else begin
                cur_fu  = scan_fu;
                use_fu  = !(starved && (scan_fu == starved_fu));
                scan_fu = (scan_fu == FW'(NFU - 1)) ? '0 : scan_fu + 1'b1;
            end
            if (use_fu) begin
                for (int unsigned j = 0; j < EWD; j++) begin
                    if (fu_resp[cur_fu][j][VB]) begin
                        if (gcnt < nfree) begin
                            claim[cur_fu][j]                 = 1'b1;
                            bundle_d[free_idx[gcnt[LW-1:0]]] = fu_resp[cur_fu][j];
                            gcnt                             = gcnt + 1'b1;
                            last_fu                          = cur_fu;
                            any_grant                        = 1'b1;
                        end else begin
                            any_deny = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Rotate past the last granted FU only when someone was left waiting.
    always_comb begin : rr_next
        rr_d = rr_q;
        if (any_grant && any_deny)
            rr_d = (last_fu == FW'(NFU - 1)) ? '0 : last_fu + 1'b1;
    end

`ifdef WB_AGE_EN
    localparam int AW = $clog2(AGE_MAX + 1);

    logic [NFU-1:0][AW-1:0] age_q, age_d;

    always_comb begin : age_pick
        starved    = 1'b0;
        starved_fu = '0;
        for (int unsigned i = 0; i < NFU; i++) begin
            if (!starved && (age_q[i] >= AW'(AGE_MAX))) begin
                starved    = 1'b1;
                starved_fu = FW'(i);
            end
        end
    end

    always_comb begin : age_next
        logic any_v;
        age_d = '0;
        any_v = 1'b0;
        for (int unsigned i = 0; i < NFU; i++) begin
            any_v = 1'b0;
            for (int unsigned j = 0; j < EWD; j++)
                any_v = any_v | fu_resp[i][j][VB];
            if (any_v && !(|claim[i]))
                age_d[i] = (age_q[i] >= AW'(AGE_MAX)) ? age_q[i] : age_q[i] + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) age_q <= '0;
        else      age_q <= age_d;
    end
`else
    assign starved    = 1'b0;
    assign starved_fu = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bundle_q <= '0;
            rr_q     <= '0;
        end else begin
            bundle_q <= bundle_d;
            rr_q     <= rr_d;
        end
    end

    assign fu_claim   = rst ? claim : '0;
    assign exe_bundle = bundle_q;

endmodule
